// File: rtl/tas_avg_stream.sv
// tas_avg_stream: serial byte deserialiser, header hunt, N-sample average written to a down-counting RAM address
module tas_avg_stream #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2,
  parameter int ADDR_W = 11,
  parameter logic [DATA_W-1:0] HDR0 = 8'hA5,
  parameter logic [DATA_W-1:0] HDR1 = 8'hC3,
  parameter int ROUND = 0
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              frame_err
);
  localparam int AW = DATA_W + LOG2_N;
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0] HALF = (ROUND != 0) ? (AW+1)'(1) << (LOG2_N - 1) : '0;
  typedef enum logic [1:0] {HUNT, COLLECT, WRITE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, byte_q, byte_d, data_q, data_d, res;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0] acc_q, acc_d, nxt;
  logic [AW:0] sum, quo;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] naddr_q, naddr_d, addr_q, addr_d;
  logic byte_valid_q, byte_valid_d, frame_err_q, frame_err_d, wr_n_q, wr_n_d;
  logic abort, done, hdr;
  always_comb begin
    nxt = acc_q + AW'(byte_q);
    sum = {1'b0, nxt} + HALF;
    quo = sum >> LOG2_N;
    res = |quo[AW:DATA_W] ? '1 : quo[DATA_W-1:0];
    abort = !data_ena && bcnt_q != '0;
    done = data_ena && bcnt_q == BW'(DATA_W - 1);
    shift_d = data_ena ? {serial_data, shift_q[DATA_W-1:1]} : '0;
    bcnt_d = (data_ena && !done) ? bcnt_q + 1'b1 : '0;
    byte_d = done ? shift_d : byte_q;
    byte_valid_d = done;
    frame_err_d = abort;
    hdr = byte_valid_q && (byte_q == HDR0 || byte_q == HDR1);
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    naddr_d = naddr_q;
    data_d = data_q;
    addr_d = addr_q;
    wr_n_d = 1'b1;
    if (state_q == COLLECT) begin
      if (abort) state_d = HUNT;
      else if (byte_valid_q) begin
        acc_d = nxt;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = WRITE;
          wr_n_d = 1'b0;
          data_d = res;
          addr_d = naddr_q;
          naddr_d = naddr_q - 1'b1;
        end
      end
    end else begin
      state_d = hdr ? COLLECT : HUNT;
      acc_d = hdr ? '0 : acc_q;
      cnt_d = hdr ? '0 : cnt_q;
    end
  end
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      shift_q <= '0;
      bcnt_q <= '0;
      byte_q <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      naddr_q <= '1;
      data_q <= '0;
      addr_q <= '0;
      wr_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q <= bcnt_d;
      byte_q <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q <= frame_err_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      naddr_q <= naddr_d;
      data_q <= data_d;
      addr_q <= addr_d;
      wr_n_q <= wr_n_d;
    end
  end
  assign ram_wr_n = wr_n_q;
  assign ram_data = data_q;
  assign ram_addr = addr_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_tas_avg_stream.sv
// tb_tas_avg_stream: directed packets against default, rounding and 2-bit-address instances
module tb_tas_avg_stream;
  logic clk = 1'b0, rst_n, sd, en;
  logic w0, w1, w2, fe0, fe1, fe2;
  logic [7:0] rd0, rd1, rd2;
  logic [10:0] ra0, ra1;
  logic [1:0] ra2;
  int tests = 0, fails = 0, nw0 = 0, nw1 = 0, nw2 = 0, nfe0 = 0;
  always #10 clk = ~clk;
  tas_avg_stream d0 (.clk_50(clk), .reset_n(rst_n), .serial_data(sd), .data_ena(en),
    .ram_wr_n(w0), .ram_data(rd0), .ram_addr(ra0), .frame_err(fe0));
  tas_avg_stream #(.ROUND(1)) d1 (.clk_50(clk), .reset_n(rst_n), .serial_data(sd), .data_ena(en),
    .ram_wr_n(w1), .ram_data(rd1), .ram_addr(ra1), .frame_err(fe1));
  tas_avg_stream #(.ADDR_W(2)) d2 (.clk_50(clk), .reset_n(rst_n), .serial_data(sd), .data_ena(en),
    .ram_wr_n(w2), .ram_data(rd2), .ram_addr(ra2), .frame_err(fe2));
  always @(negedge clk) begin
    if (!w0) nw0++;
    if (!w1) nw1++;
    if (!w2) nw2++;
    if (fe0) nfe0++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sd = b[i];
      en = 1'b1;
    end
    if (gap) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask
  task automatic pkt(input logic [7:0] a, b, c, d, e, input bit b2b);
    send(a, !b2b);
    send(b, !b2b);
    send(c, !b2b);
    send(d, !b2b);
    send(e, 1'b1);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    sd = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_n", w0, 1);
    chk("rst_data", rd0, 0);
    chk("rst_addr", ra0, 0);
    chk("rst_ferr", fe0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hA5, 1); send(8'h0A, 1); send(8'h14, 1); send(8'h1E, 1); send(8'h28, 1);
    chk("lat_pre", w0, 1);
    @(negedge clk);
    chk("lat_wr_n", w0, 0);
    chk("p1_data", rd0, 8'h19);
    chk("p1_addr", ra0, 11'h7FF);
    @(negedge clk);
    chk("p1_wr_hi", w0, 1);
    repeat (3) @(negedge clk);
    chk("p1_held", rd0, 8'h19);
    chk("p1_cnt", nw0, 1);
    chk("p1_rnd", rd1, 8'h19);
    chk("p1_a2", ra2, 3);
    pkt(8'hC3, 8'h04, 8'h04, 8'h04, 8'h04, 1);
    chk("p2_data", rd0, 8'h04);
    chk("p2_addr", ra0, 11'h7FE);
    chk("p2_cnt", nw0, 2);
    chk("p2_a2", ra2, 2);
    send(8'h5A, 1);
    send(8'h00, 1);
    pkt(8'hA5, 8'h01, 8'h02, 8'h03, 8'h06, 0);
    chk("hunt_data", rd0, 8'h03);
    chk("hunt_addr", ra0, 11'h7FD);
    chk("hunt_cnt", nw0, 3);
    chk("hunt_a2", ra2, 1);
    send(8'hA5, 1);
    send(8'h10, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sd = 1'b1;
      en = 1'b1;
    end
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("part_ferr", nfe0, 1);
    chk("part_nowr", nw0, 3);
    pkt(8'hA5, 8'h08, 8'h08, 8'h08, 8'h08, 0);
    chk("part_data", rd0, 8'h08);
    chk("part_addr", ra0, 11'h7FC);
    chk("part_cnt", nw0, 4);
    chk("wrap_a0", ra2, 0);
    pkt(8'hA5, 8'h01, 8'h02, 8'h02, 8'h02, 0);
    chk("trunc", rd0, 8'h01);
    chk("round", rd1, 8'h02);
    chk("wrap_a3", ra2, 3);
    pkt(8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    chk("sat_trunc", rd0, 8'hFF);
    chk("sat_round", rd1, 8'hFF);
    chk("sat_a2", ra2, 2);
    chk("cnt_rnd", nw1, 6);
    send(8'hA5, 1);
    send(8'h01, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_wr_n", w0, 1);
    chk("mid_data", rd0, 0);
    chk("mid_addr", ra2, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_nowr", nw0, 6);
    pkt(8'hA5, 8'h04, 8'h04, 8'h04, 8'h04, 0);
    chk("post_a2", ra2, 3);
    chk("post_a0", ra0, 11'h7FF);
    chk("post_data", rd0, 8'h04);
    chk("post_cnt", nw2, 7);
    chk("ferr_total", nfe0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tas_avg_stream.md
Name: tas_avg_stream

Overview:
Parametrised second-generation temperature averaging block, running entirely in the clk_50 domain.
- Deserialises an LSB-first serial byte stream.
- Hunts for either of two header bytes, then accumulates 2^LOG2_N data bytes.
- Writes the truncated or rounded average to an external RAM at an address that counts down and wraps.
- Flags malformed (partial) bytes.

Parameters:
DATA_W, 8, serial word width in bits (>=2)
LOG2_N, 2, log2 of samples averaged per packet (N = 2^LOG2_N, LOG2_N >= 1)
ADDR_W, 11, RAM address width
HDR0, 8'hA5, first accepted header value (DATA_W bits)
HDR1, 8'hC3, second accepted header value (DATA_W bits)
ROUND, 0, 0 = truncate average; 1 = round half-up, saturate to all-ones

Ports:
clk_50  in  1  system clock; all state in this domain
reset_n  in  1  asynchronous, active-low reset
serial_data  in  1  serial bit, sampled on rising clk_50 when data_ena=1
data_ena  in  1  high for the DATA_W consecutive cycles of one byte; low between bytes
ram_wr_n  out  1  active-low write strobe, exactly one cycle per packet
ram_data  out  DATA_W  average value; valid while ram_wr_n=0, held afterwards
ram_addr  out  ADDR_W  write address; valid while ram_wr_n=0, held afterwards
frame_err  out  1  one-cycle pulse when a byte is aborted part-way

Behaviour:
- Reset values: ram_wr_n=1, ram_data=0, ram_addr=0, frame_err=0. Internal state: FSM=HUNT, bit count=0, accumulator=0, sample count=0, next-address register=2^ADDR_W-1.
- Deserialiser:
  - Each edge with data_ena=1 shifts serial_data in at the MSB and shifts right, so the first bit received ends up at the LSB.
  - On the DATA_W-th consecutive bit, the byte is registered and byte_valid pulses for the following cycle. Bit count then returns to 0.
  - Back-to-back bytes are allowed: data_ena stays high and the next bit is bit 0 of the next byte.
- Partial byte: data_ena low while bit count is 1..DATA_W-1.
  - Shifter is discarded, bit count goes to 0, frame_err pulses on the next cycle.
  - If the FSM is in COLLECT, the packet is aborted: FSM goes to HUNT, no RAM write occurs.
- FSM states:
  - HUNT: on byte_valid, if byte == HDR0 or HDR1, go to COLLECT and clear accumulator and sample count; otherwise stay in HUNT.
  - COLLECT: on byte_valid, acc += byte and count += 1. Header values are treated as data (no resync). When count reaches N, go to WRITE.
  - WRITE: one cycle. Drive ram_wr_n=0, ram_data=result, ram_addr=next-address. Decrement next-address (modulo 2^ADDR_W; 0 wraps to all-ones). Return to HUNT.
- Latency: ram_wr_n is low in the cycle immediately after the byte_valid cycle of the N-th data byte.
- Arithmetic:
  - Accumulator width is DATA_W+LOG2_N and cannot overflow.
  - ROUND=0: result = acc >> LOG2_N.
  - ROUND=1: result = (acc + 2^(LOG2_N-1)) >> LOG2_N, computed with one extra bit and saturated to 2^DATA_W-1.
- Simultaneous events: a byte completing in the WRITE cycle is accepted by HUNT (header detection is not lost). frame_err and a write may coincide and are independent.
- Reset asserted mid-packet: everything returns to reset values immediately. Next write address restarts at 2^ADDR_W-1.

Test Plan:
- Basic packet (defaults): bytes A5,0A,14,1E,28 -> single ram_wr_n low pulse, ram_data=0x19, ram_addr=0x7FF.
- Second packet: C3,04,04,04,04 -> ram_data=0x04, ram_addr=0x7FE. Exactly one strobe per packet.
- Header hunt: bytes 5A,00,A5,01,02,03,06 -> 5A and 00 ignored, one write with ram_data=0x03 (12>>2).
- Partial byte: A5,10, then 3 bits with data_ena dropped -> frame_err pulse, no write. Then A5,08,08,08,08 -> ram_data=0x08.
- Rounding (ROUND=1): A5,01,02,02,02 -> ram_data=0x02 (ROUND=0 gives 0x01). A5,FF,FF,FF,FF -> 0xFF saturated.
- Wrap and reset (ADDR_W=2): five packets -> addresses 3,2,1,0,3. Assert reset_n mid-COLLECT -> no write, next packet writes address 3.
